// File: rtl/pwl_table_loader.sv
// Double-buffered {offset, slope} coefficient table for the PWL evaluator.
// Host streams a full table into the shadow bank; a one-cycle commit swaps banks.
module pwl_table_loader #(
  parameter int table_addr_bits = 8,
  parameter int offset_bits     = 16,
  parameter int slope_bits      = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load_start,
  input  logic [offset_bits+slope_bits-1:0]   load_data,
  input  logic                                load_valid,
  output logic                                load_ready,
  output logic                                load_done,
  output logic                                active_bank,
  output logic                                table_valid,
  input  logic [table_addr_bits-1:0]          addr_to_rom,
  output logic [offset_bits+slope_bits-1:0]   data_from_rom
);

  localparam int W = offset_bits + slope_bits;
  localparam int N = 1 << table_addr_bits;
  localparam logic [table_addr_bits-1:0] PTR_LAST = {table_addr_bits{1'b1}};
  localparam logic [table_addr_bits-1:0] PTR_ONE  = {{(table_addr_bits-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [table_addr_bits-1:0] wr_ptr_q, wr_ptr_d;
  logic                       active_bank_q, active_bank_d;
  logic                       table_valid_q, table_valid_d;
  logic                       load_ready_q, load_ready_d;
  logic                       load_done_q, load_done_d;
  logic [W-1:0]               data_q, data_d;
  logic                       wr_en_s;
  logic [W-1:0]               rd_word_s;

  logic [W-1:0] bank0_mem [N];
  logic [W-1:0] bank1_mem [N];

  // Next-state, pointer and handshake logic for the load FSM
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    active_bank_d = active_bank_q;
    table_valid_d = table_valid_q;
    load_done_d   = 1'b0;
    wr_en_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
        end else begin
          state_d  = IDLE;
        end
      end
      LOAD: begin
        wr_en_s = load_valid;
        // A restart wins over the pointer even when a beat lands in the same cycle
        if (load_start) begin
          wr_ptr_d = '0;
        end else if (load_valid) begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (wr_ptr_q == PTR_LAST) begin
            state_d = COMMIT;
          end else begin
            state_d = LOAD;
          end
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      COMMIT: begin
        state_d       = IDLE;
        active_bank_d = ~active_bank_q;
        table_valid_d = 1'b1;
        load_done_d   = 1'b1;
      end
      default: begin
        state_d  = IDLE;
        wr_ptr_d = '0;
      end
    endcase
    load_ready_d = (state_d == LOAD);
  end

  // Read mux from the active bank, gated until a table has been committed
  always_comb begin
    if (active_bank_q) begin
      rd_word_s = bank1_mem[addr_to_rom];
    end else begin
      rd_word_s = bank0_mem[addr_to_rom];
    end
    if (table_valid_q) begin
      data_d = rd_word_s;
    end else begin
      data_d = '0;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      active_bank_q <= 1'b0;
      table_valid_q <= 1'b0;
      load_ready_q  <= 1'b0;
      load_done_q   <= 1'b0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      active_bank_q <= active_bank_d;
      table_valid_q <= table_valid_d;
      load_ready_q  <= load_ready_d;
      load_done_q   <= load_done_d;
      data_q        <= data_d;
    end
  end

  // Shadow-bank writes; storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      if (active_bank_q) begin
        bank0_mem[wr_ptr_q] <= load_data;
      end else begin
        bank1_mem[wr_ptr_q] <= load_data;
      end
    end
  end

  assign load_ready    = load_ready_q;
  assign load_done     = load_done_q;
  assign active_bank   = active_bank_q;
  assign table_valid   = table_valid_q;
  assign data_from_rom = data_q;

endmodule
